// File: rtl/reg_dump_uart.sv
// reg_dump_uart: walks the register-file read port from x0 upward and sends
// each 32-bit value out a UART TX line as four big-endian 8N1 bytes.
//
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset
//   start  - dump request, honoured only while idle
//   ra     - register-file read address (registered reg_idx)
//   rd     - register-file read data, combinational in ra
//   tx     - UART serial out, idle high
//   busy   - dump in progress
//   done   - one-cycle pulse when the last stop bit ends
//
// Build option: define REG_DUMP_INDEX_EN to precede each register's data
// bytes with an index byte {3'b000, reg_idx}.
module reg_dump_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NREGS        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  ra,
  input  logic [31:0] rd,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
`ifdef REG_DUMP_INDEX_EN
  localparam int unsigned LAST_BYTE = 4;
`else
  localparam int unsigned LAST_BYTE = 3;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [4:0]       reg_idx_q, reg_idx_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_end;
  logic [2:0]       nxt_byte_idx;

  // Big-endian data byte k of a 32-bit word.
  function automatic logic [7:0] data_byte(input logic [31:0] word, input logic [1:0] k);
    case (k)
      2'd0:    data_byte = word[31:24];
      2'd1:    data_byte = word[23:16];
      2'd2:    data_byte = word[15:8];
      default: data_byte = word[7:0];
    endcase
  endfunction

  assign bit_end      = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign nxt_byte_idx = byte_idx_q + 3'd1;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      reg_idx_q  <= 5'd0;
      byte_idx_q <= 3'd0;
      bit_idx_q  <= 3'd0;
      clk_cnt_q  <= '0;
      shadow_q   <= 32'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      clk_cnt_q  <= clk_cnt_d;
      shadow_q   <= shadow_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; tx_d is the line level of the state being entered.
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    clk_cnt_d  = clk_cnt_q;
    shadow_d   = shadow_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          reg_idx_d = 5'd0;
          busy_d    = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: begin
        // Snapshot rd now; later register writes do not affect this frame.
        shadow_d   = rd;
        byte_idx_d = 3'd0;
        clk_cnt_d  = '0;
`ifdef REG_DUMP_INDEX_EN
        shift_d    = {3'b000, reg_idx_q};
`else
        shift_d    = data_byte(rd, 2'd0);
`endif
        tx_d       = 1'b0;
        state_d    = S_START;
      end

      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (byte_idx_q < 3'(LAST_BYTE)) begin
            byte_idx_d = nxt_byte_idx;
`ifdef REG_DUMP_INDEX_EN
            shift_d    = data_byte(shadow_q, 2'(nxt_byte_idx - 3'd1));
`else
            shift_d    = data_byte(shadow_q, 2'(nxt_byte_idx));
`endif
            tx_d       = 1'b0;
            state_d    = S_START;
          end else if (reg_idx_q < 5'(NREGS - 1)) begin
            reg_idx_d = reg_idx_q + 5'd1;
            tx_d      = 1'b1;
            state_d   = S_FETCH;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign ra   = reg_idx_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_reg_dump_uart.sv
// Directed bench for reg_dump_uart with CLKS_PER_BIT = 4, NREGS = 2.
// Cycle k of a dump is the cycle seen at the k-th negedge after the posedge
// that samples start (k = 1 is the FETCH of register 0).
module tb_reg_dump_uart;

  localparam int unsigned CPB = 4;
  localparam int unsigned NR  = 2;
`ifdef REG_DUMP_INDEX_EN
  localparam int unsigned BYTES_PER_REG = 5;
`else
  localparam int unsigned BYTES_PER_REG = 4;
`endif
  localparam int unsigned REG_CYC = 1 + BYTES_PER_REG * 10 * CPB;
  localparam int unsigned DONE_K  = 1 + NR * REG_CYC;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] regs [0:31];
  logic [7:0]  rx_bytes [$];
  logic [7:0]  exp_q [$];
  logic        tx_hist [0:511];
  int          frame_err = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  assign rd = regs[ra];

  reg_dump_uart #(.CLKS_PER_BIT(CPB), .NREGS(NR)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ra    (ra),
    .rd    (rd),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle-exact UART receiver: samples the first cycle of every bit.
  initial begin : uart_rx
    logic [7:0] b;
    b = 8'd0;
    forever begin
      @(negedge clk);
      if (rst && tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        rx_bytes.push_back(b);
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) frame_err++;
        repeat (CPB - 1) @(negedge clk);
      end
    end
  end

  // Expected byte stream for register contents r0, r1.
  task automatic set_exp(input logic [31:0] r0, input logic [31:0] r1);
    exp_q = {};
`ifdef REG_DUMP_INDEX_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(r0[31:24]); exp_q.push_back(r0[23:16]);
    exp_q.push_back(r0[15:8]);  exp_q.push_back(r0[7:0]);
`ifdef REG_DUMP_INDEX_EN
    exp_q.push_back(8'h01);
`endif
    exp_q.push_back(r1[31:24]); exp_q.push_back(r1[23:16]);
    exp_q.push_back(r1[15:8]);  exp_q.push_back(r1[7:0]);
  endtask

  task automatic run_dump(input bit pre_started, input bit inj_start, input bit mod_reg1,
                          input bit restart, input string nm);
    int base;
    int fe0;
    int done_cnt;
    int done_k;
    int last_k;
    base     = rx_bytes.size();
    fe0      = frame_err;
    done_cnt = 0;
    done_k   = 0;
    last_k   = restart ? int'(DONE_K) : int'(DONE_K) + 2;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      tx_hist[k] = tx;
      if (k == 1) begin
        start = 1'b0;
        check({nm, ".busy_rise"}, 64'(busy), 64'd1);
        check({nm, ".ra_fetch0"}, 64'(ra), 64'd0);
      end
      if (k == 2) check({nm, ".start_bit"}, 64'(tx), 64'd0);
      if (k == int'(REG_CYC) + 1) begin
        check({nm, ".ra_fetch1"}, 64'(ra), 64'd1);
        check({nm, ".gap_tx"}, 64'(tx), 64'd1);
      end
      if (inj_start && k == 50) start = 1'b1;
      if (inj_start && k == 51) start = 1'b0;
      if (mod_reg1 && k == int'(REG_CYC) + 2) regs[1] = 32'h1234_5678;
      if (done) begin
        done_cnt++;
        done_k = k;
        check({nm, ".busy_at_done"}, 64'(busy), 64'd0);
      end
      if (restart && k == int'(DONE_K)) start = 1'b1;
    end
    check({nm, ".done_count"}, 64'(done_cnt), 64'd1);
    check({nm, ".done_cycle"}, 64'(done_k), 64'(DONE_K));
    check({nm, ".frame_err"}, 64'(frame_err - fe0), 64'd0);
    check({nm, ".nbytes"}, 64'(rx_bytes.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx_bytes.size())
        check($sformatf("%s.byte%0d", nm, i), 64'(rx_bytes[base + i]), 64'(exp_q[i]));
    end
  endtask

  initial begin : main
    logic [9:0]  seg;
    logic [39:0] got_v;
    logic [39:0] exp_v;
    int          bt_k;

    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    for (int i = 0; i < 512; i++) tx_hist[i] = 1'b1;
    start = 1'b0;
    rst   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.tx", 64'(tx), 64'd1);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.ra", 64'(ra), 64'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle.tx", 64'(tx), 64'd1);
    check("idle.busy", 64'(busy), 64'd0);
    check("idle.nbytes", 64'(rx_bytes.size()), 64'd0);

    // Basic dump: 00000000, DEADBEEF
    regs[1] = 32'hDEAD_BEEF;
    set_exp(32'h0000_0000, 32'hDEAD_BEEF);
    run_dump(1'b0, 1'b0, 1'b0, 1'b0, "basic");

    // Bit timing on byte A5
    regs[0] = 32'hA500_0000;
    set_exp(32'hA500_0000, 32'hDEAD_BEEF);
    run_dump(1'b0, 1'b0, 1'b0, 1'b0, "bittime");
    bt_k = 2 + int'(BYTES_PER_REG - 4) * 40;
    seg  = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      got_v[i] = tx_hist[bt_k + i];
      exp_v[i] = seg[i / CPB];
    end
    check("bittime.pre_idle", 64'(tx_hist[bt_k - 1]), 64'd1);
    check("bittime.frame", 64'(got_v), 64'(exp_v));
    regs[0] = 32'd0;

    // start while busy is ignored
    set_exp(32'h0000_0000, 32'hDEAD_BEEF);
    run_dump(1'b0, 1'b1, 1'b0, 1'b0, "ignore");

    // start in the done cycle launches a second dump
    run_dump(1'b0, 1'b0, 1'b0, 1'b1, "restart1");
    run_dump(1'b1, 1'b0, 1'b0, 1'b0, "restart2");

    // register changed after its FETCH: snapshot value is sent
    run_dump(1'b0, 1'b0, 1'b1, 1'b0, "snap");
    regs[1] = 32'hDEAD_BEEF;

    // Reset during a data bit of byte 0 (all zero data)
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("abort.pre_tx", 64'(tx), 64'd0);
    check("abort.pre_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("abort.tx", 64'(tx), 64'd1);
    check("abort.busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("abort.ra", 64'(ra), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("abort.idle_tx", 64'(tx), 64'd1);
    check("abort.idle_busy", 64'(busy), 64'd0);

    // Normal dump after the abort
    run_dump(1'b0, 1'b0, 1'b0, 1'b0, "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
